// File: rtl/rc4_phase_sequencer.sv
// Sequences the INIT, KSA and PRGA engines over one shared single-port S-memory, with a watchdog on each phase.
// Control outputs are registered (1-cycle latency); the memory port mux is combinational from state, and an engine waits by holding done low.
module rc4_phase_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic              init_start,
   input  logic              init_done,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_data,
   input  logic              init_wren,
   output logic              ksa_start,
   input  logic              ksa_done,
   input  logic [ADDR_W-1:0] ksa_addr,
   input  logic [DATA_W-1:0] ksa_data,
   input  logic              ksa_wren,
   output logic              prga_start,
   input  logic              prga_done,
   input  logic [ADDR_W-1:0] prga_addr,
   input  logic [DATA_W-1:0] prga_data,
   input  logic              prga_wren,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_data,
   output logic              s_wren,
   output logic [1:0]        phase,
   output logic              busy,
   output logic              done,
   output logic              fault
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_WAIT,
      S_KSA_WAIT,
      S_PRGA_WAIT,
      S_DONE,
      S_FAULT
   } state_t;

   state_t          state;
   state_t          state_nxt;
   state_t          advance;
   logic [WD_W-1:0] watchdog;
   logic            cur_done;
   logic            in_wait;

   function automatic logic [1:0] phase_of(input state_t s);
      case (s)
         S_INIT_WAIT: phase_of = 2'd1;
         S_KSA_WAIT:  phase_of = 2'd2;
         S_PRGA_WAIT: phase_of = 2'd3;
         default:     phase_of = 2'd0;
      endcase
   endfunction

   // Only the owning engine's done is looked at; the others are ignored.
   always_comb begin
      cur_done = 1'b0;
      in_wait  = 1'b0;
      advance  = S_IDLE;
      case (state)
         S_INIT_WAIT: begin
            cur_done = init_done;
            in_wait  = 1'b1;
            advance  = S_KSA_WAIT;
         end
         S_KSA_WAIT: begin
            cur_done = ksa_done;
            in_wait  = 1'b1;
            advance  = S_PRGA_WAIT;
         end
         S_PRGA_WAIT: begin
            cur_done = prga_done;
            in_wait  = 1'b1;
            advance  = S_DONE;
         end
         default: begin
            cur_done = 1'b0;
            in_wait  = 1'b0;
            advance  = S_IDLE;
         end
      endcase
   end

   // Done beats a coincident watchdog expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (go) state_nxt = S_INIT_WAIT;
         end
         S_INIT_WAIT, S_KSA_WAIT, S_PRGA_WAIT: begin
            if (cur_done)                  state_nxt = advance;
            else if (watchdog == WD_LAST)  state_nxt = S_FAULT;
         end
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         watchdog   <= '0;
         init_start <= 1'b0;
         ksa_start  <= 1'b0;
         prga_start <= 1'b0;
         phase      <= 2'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state <= state_nxt;
         // Any state change clears the counter, so each WAIT entry starts from zero.
         if (state_nxt != state)
            watchdog <= '0;
         else if (in_wait)
            watchdog <= watchdog + WD_W'(1);
         init_start <= (state_nxt == S_INIT_WAIT);
         ksa_start  <= (state_nxt == S_KSA_WAIT);
         prga_start <= (state_nxt == S_PRGA_WAIT);
         phase      <= phase_of(state_nxt);
         busy       <= (state_nxt == S_INIT_WAIT) || (state_nxt == S_KSA_WAIT) ||
                       (state_nxt == S_PRGA_WAIT);
         done       <= (state_nxt == S_DONE);
         fault      <= (state_nxt == S_FAULT);
      end
   end

   always_comb begin
      s_addr = '0;
      s_data = '0;
      s_wren = 1'b0;
      case (state)
         S_INIT_WAIT: begin
            s_addr = init_addr;
            s_data = init_data;
            s_wren = init_wren;
         end
         S_KSA_WAIT: begin
            s_addr = ksa_addr;
            s_data = ksa_data;
            s_wren = ksa_wren;
         end
         S_PRGA_WAIT: begin
            s_addr = prga_addr;
            s_data = prga_data;
            s_wren = prga_wren;
         end
         default: begin
            s_addr = '0;
            s_data = '0;
            s_wren = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: two instances (default watchdog, and a short one of 16 cycles)
// share all inputs; each is compared every cycle against its own phase-level reference model.
module tb_rc4_phase_sequencer;

   logic       clk = 1'b0;
   logic       reset, go;
   logic       init_done, ksa_done, prga_done;
   logic [7:0] init_addr, ksa_addr, prga_addr;
   logic [7:0] init_data, ksa_data, prga_data;
   logic       init_wren, ksa_wren, prga_wren;

   logic       is_l, ks_l, ps_l, busy_l, done_l, fault_l, sw_l;
   logic [1:0] ph_l;
   logic [7:0] sa_l, sd_l;
   logic       is_s, ks_s, ps_s, busy_s, done_s, fault_s, sw_s;
   logic [1:0] ph_s;
   logic [7:0] sa_s, sd_s;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   // Reference model: owning phase (0 = nobody), completed / faulted flags, cycles waited.
   int m_ph [2];
   bit m_dn [2];
   bit m_ft [2];
   int m_wt [2];
   int m_to [2] = '{4096, 16};

   always #5 clk = ~clk;

   rc4_phase_sequencer u_long (
      .clk(clk), .reset(reset), .go(go),
      .init_start(is_l), .init_done(init_done), .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
      .ksa_start(ks_l), .ksa_done(ksa_done), .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
      .prga_start(ps_l), .prga_done(prga_done), .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
      .s_addr(sa_l), .s_data(sd_l), .s_wren(sw_l),
      .phase(ph_l), .busy(busy_l), .done(done_l), .fault(fault_l)
   );

   rc4_phase_sequencer #(.TIMEOUT(16)) u_short (
      .clk(clk), .reset(reset), .go(go),
      .init_start(is_s), .init_done(init_done), .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
      .ksa_start(ks_s), .ksa_done(ksa_done), .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
      .prga_start(ps_s), .prga_done(prga_done), .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
      .s_addr(sa_s), .s_data(sd_s), .s_wren(sw_s),
      .phase(ph_s), .busy(busy_s), .done(done_s), .fault(fault_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit done_of(input int p);
      case (p)
         1:       done_of = init_done;
         2:       done_of = ksa_done;
         3:       done_of = prga_done;
         default: done_of = 1'b0;
      endcase
   endfunction

   function automatic logic [16:0] port_of(input int p);
      case (p)
         1:       port_of = {init_wren, init_data, init_addr};
         2:       port_of = {ksa_wren, ksa_data, ksa_addr};
         3:       port_of = {prga_wren, prga_data, prga_addr};
         default: port_of = '0;
      endcase
   endfunction

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_ph[d] = 0; m_dn[d] = 0; m_ft[d] = 0; m_wt[d] = 0;
         end else if (m_ft[d]) begin
            m_ph[d] = 0;
         end else if (m_ph[d] == 0) begin
            if (go) begin m_ph[d] = 1; m_dn[d] = 0; m_wt[d] = 0; end
         end else if (done_of(m_ph[d])) begin
            if (m_ph[d] == 3) begin m_ph[d] = 0; m_dn[d] = 1; end
            else m_ph[d] = m_ph[d] + 1;
            m_wt[d] = 0;
         end else if (m_wt[d] == m_to[d] - 1) begin
            m_ft[d] = 1; m_ph[d] = 0;
         end else begin
            m_wt[d] = m_wt[d] + 1;
         end
      end
   endtask

   task automatic check_dut(input string n, input int d,
                            input logic is, input logic ks, input logic ps, input logic [1:0] ph,
                            input logic b, input logic dn, input logic ft,
                            input logic [7:0] sa, input logic [7:0] sd, input logic sw);
      logic [16:0] port;
      port = port_of(m_ph[d]);
      check({n, ".init_start"}, is, m_ph[d] == 1);
      check({n, ".ksa_start"},  ks, m_ph[d] == 2);
      check({n, ".prga_start"}, ps, m_ph[d] == 3);
      check({n, ".phase"},      ph, m_ph[d]);
      check({n, ".busy"},       b,  m_ph[d] != 0);
      check({n, ".done"},       dn, m_dn[d]);
      check({n, ".fault"},      ft, m_ft[d]);
      check({n, ".s_addr"},     sa, port[7:0]);
      check({n, ".s_data"},     sd, port[15:8]);
      check({n, ".s_wren"},     sw, port[16]);
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_en) begin
         check_dut("long",  0, is_l, ks_l, ps_l, ph_l, busy_l, done_l, fault_l, sa_l, sd_l, sw_l);
         check_dut("short", 1, is_s, ks_s, ps_s, ph_s, busy_s, done_s, fault_s, sa_s, sd_s, sw_s);
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic rnd_bus();
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
      ksa_addr  = 8'($urandom); ksa_data  = 8'($urandom); ksa_wren  = 1'($urandom);
      prga_addr = 8'($urandom); prga_data = 8'($urandom); prga_wren = 1'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1; go = 1'b0; rnd_bus(); tick(); reset = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1; rnd_bus(); tick(); go = 1'b0;
   endtask

   task automatic run_phase(input int p, input int lat);
      for (int i = 1; i <= lat; i++) begin
         rnd_bus();
         init_done = (p == 1) && (i == lat);
         ksa_done  = (p == 2) && (i == lat);
         prga_done = (p == 3) && (i == lat);
         tick();
      end
      init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
   endtask

   initial begin
      reset = 1'b1; go = 1'b0;
      init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
      rnd_bus();

      // Reset for three cycles, then idle with go low.
      tick();
      chk_en = 1'b1;
      tick(); tick();
      reset = 1'b0;
      repeat (20) begin rnd_bus(); tick(); end
      check("t1_busy", busy_l, 0);
      check("t1_swren", sw_l, 0);

      // INIT fill, with KSA trying to write on the side.
      pulse_go();
      for (int i = 0; i < 256; i++) begin
         rnd_bus();
         init_addr = i[7:0]; init_data = i[7:0]; init_wren = 1'b1;
         ksa_wren = 1'b1;
         init_done = (i == 255);
         tick();
      end
      init_done = 1'b0;
      check("t2_init_start", is_l, 0);
      check("t2_ksa_start", ks_l, 1);
      check("t2_phase", ph_l, 2);
      run_phase(2, 768);
      check("t3_phase", ph_l, 3);
      run_phase(3, 32);
      check("t3_done", done_l, 1);
      check("t3_busy", busy_l, 0);

      // KSA stalls: short watchdog trips on its 17th cycle; go is ignored afterwards.
      do_reset();
      pulse_go();
      run_phase(1, 1);
      for (int k = 1; k <= 30; k++) begin
         rnd_bus();
         ksa_wren = 1'b1;
         go = (k % 5 == 0);
         tick();
         if (k == 15) check("t4_no_fault_yet", fault_s, 0);
         if (k == 16) check("t4_fault", fault_s, 1);
      end
      go = 1'b0;
      check("t4_phase", ph_s, 0);
      check("t4_swren", sw_s, 0);
      check("t4_long_phase", ph_l, 2);

      // KSA done exactly at the last allowed cycle.
      do_reset();
      pulse_go();
      run_phase(1, 1);
      run_phase(2, 16);
      check("t5_phase", ph_s, 3);
      check("t5_fault", fault_s, 0);
      run_phase(3, 1);
      check("t5_done", done_s, 1);

      // Reset mid-KSA, restart, then re-run from DONE.
      do_reset();
      pulse_go();
      run_phase(1, 5);
      for (int k = 1; k <= 100; k++) begin
         rnd_bus();
         ksa_wren = 1'b1;
         reset = (k == 100);
         tick();
      end
      reset = 1'b0;
      check("t6_ksa_start", ks_l, 0);
      check("t6_swren", sw_l, 0);
      check("t6_phase", ph_l, 0);
      pulse_go();
      check("t6_restart_phase", ph_s, 1);
      run_phase(1, 16);
      run_phase(2, 10);
      run_phase(3, 2);
      check("t6_done", done_s, 1);
      pulse_go();
      check("t6_rerun_phase", ph_l, 1);
      run_phase(1, 16);
      run_phase(2, 16);
      run_phase(3, 16);
      check("t6_rerun_done", done_s, 1);

      // Random traffic, including stray dones from non-owning engines.
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         go        = ($urandom_range(0, 7) == 0);
         init_done = ($urandom_range(0, 11) == 0);
         ksa_done  = ($urandom_range(0, 11) == 0);
         prga_done = ($urandom_range(0, 11) == 0);
         rnd_bus();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/rc4_phase_sequencer.md
Name: rc4_phase_sequencer

Overview:
- Top-level controller for the shared 256x8 S-memory in the RC4 datapath.
- Runs three phase engines in fixed order:
  - INIT: S[i]=i fill.
  - KSA: key-schedule swap loop.
  - PRGA: keystream/decrypt loop.
- Handles each engine with a start/done handshake and muxes exactly one engine's write/address port onto the single-port S-memory.
- Includes a per-phase watchdog and exposes busy/done/fault status to the top level.

Parameters:
- ADDR_W, 8, S-memory address width.
- DATA_W, 8, S-memory data width.
- TIMEOUT, 4096, max cycles allowed in any phase-wait state before fault; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  request to run full INIT->KSA->PRGA sequence; sampled in IDLE/DONE only
- init_start  out  1  start level to INIT engine
- init_done  in  1  INIT engine completion level
- init_addr  in  ADDR_W  INIT engine memory address
- init_data  in  DATA_W  INIT engine write data
- init_wren  in  1  INIT engine write enable
- ksa_start  out  1  start level to KSA engine
- ksa_done  in  1  KSA completion
- ksa_addr  in  ADDR_W  KSA address
- ksa_data  in  DATA_W  KSA write data
- ksa_wren  in  1  KSA write enable
- prga_start  out  1  start level to PRGA engine
- prga_done  in  1  PRGA completion
- prga_addr  in  ADDR_W  PRGA address
- prga_data  in  DATA_W  PRGA write data
- prga_wren  in  1  PRGA write enable
- s_addr  out  ADDR_W  S-memory address
- s_data  out  DATA_W  S-memory write data
- s_wren  out  1  S-memory write enable
- phase  out  2  current owner: 0 none, 1 INIT, 2 KSA, 3 PRGA
- busy  out  1  high in any *_WAIT state
- done  out  1  high in DONE
- fault  out  1  high in FAULT

Behaviour:

States: IDLE, INIT_WAIT, KSA_WAIT, PRGA_WAIT, DONE, FAULT. All state and counter updates happen on the rising edge of clk.

Reset:
- reset=1 at a clock edge -> state IDLE, watchdog=0.
- All registered outputs then read 0: init/ksa/prga_start, phase, busy, done, fault.
- Reset overrides every other input and is honoured mid-phase: the engine's start drops the cycle after reset is sampled.

Transitions:
- IDLE --go--> INIT_WAIT.
- INIT_WAIT --init_done--> KSA_WAIT.
- KSA_WAIT --ksa_done--> PRGA_WAIT.
- PRGA_WAIT --prga_done--> DONE.
- DONE --go--> INIT_WAIT (re-run); DONE with go=0 holds.
- FAULT is sticky; it exits only on reset.
- go is ignored in *_WAIT and FAULT.

Start signals:
- x_start is registered, equal to (state == X_WAIT).
- High from the first cycle in X_WAIT up to and including the cycle done is sampled; low the next cycle.
- Only the current phase's done is examined; done from other engines is ignored.
- A done sampled on the first WAIT cycle is accepted (minimum phase duration 1 cycle).

Memory mux (combinational from registered state):
- INIT_WAIT -> init_* ; KSA_WAIT -> ksa_* ; PRGA_WAIT -> prga_*.
- IDLE/DONE/FAULT -> s_addr=0, s_data=0, s_wren=0.
- A non-owner's wren never reaches s_wren.
- Read data from memory goes directly to the engines, outside this block.

Watchdog:
- Cleared to 0 on every entry to a *_WAIT state.
- Increments each cycle spent in that WAIT without done.
- When the counter equals TIMEOUT-1 and done=0 -> FAULT next cycle.
- If done and the timeout coincide, done wins (normal transition).
- Counter width is clog2(TIMEOUT+1) bits; it never wraps.

Status outputs:
- phase encoding: 1/2/3 in the corresponding WAIT state; 0 otherwise.
- busy = any WAIT; done = DONE; fault = FAULT. All three are mutually exclusive.

Test Plan:
1. Reset held 3 cycles, then released with go=0 -> all outputs 0, s_wren=0, state stays IDLE for 20 cycles.
2. go pulse; INIT model writes addr/data 0..255 with wren=1 and raises init_done after 256 cycles -> s_addr/s_data track init_addr, s_wren=1 for 256 cycles. Next cycle: init_start=0, ksa_start=1, phase=2.
3. Full run with done latencies 256/768/32 -> phase sequence 1,2,3, then done=1 and busy=0 exactly one cycle after prga_done. Driving ksa_wren=1 during INIT never asserts s_wren from KSA.
4. TIMEOUT=16, KSA never asserts done -> fault=1 on the 17th cycle after entering KSA_WAIT, s_wren=0, phase=0. go has no effect until reset.
5. TIMEOUT=16, ksa_done asserted on wait cycle 16 (watchdog=15) -> PRGA_WAIT entered, fault stays 0.
6. reset asserted mid-KSA (cycle 100) -> next cycle IDLE, ksa_start=0, s_wren=0. A subsequent go restarts at INIT with watchdog=0. go in DONE re-runs the sequence from phase 1.
